// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU memory stage and the data-memory responder.
// The CPU drives the request fields; the responder returns ack, read data, busy and error.
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, busy_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, busy_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, waits LATENCY edges,
// then acks once with read data or an error for misaligned/out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_r;
  logic [3:0]         cnt_r;
  logic               we_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic               ack_r;
  logic               busy_r;
  logic               err_r;
  logic [31:0]        rdata_r;
  logic [31:0]        mem_r [0:DEPTH_WORDS-1];

  logic               in_range_s;
  logic               access_s;
  logic [IDX_W-1:0]   idx_s;

  // Decode the captured address and flag the edge on which the access happens.
  always_comb begin
    in_range_s = 1'b0;
    access_s   = 1'b0;
    idx_s      = addr_r[IDX_W+1:2];
    if ((addr_r[1:0] == 2'b00) && (addr_r[31:2] < DEPTH_LIM)) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
    if ((state_r == WAIT) && (cnt_r == 4'd0)) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
  end

  // Storage is deliberately left out of reset so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (!rst_i && access_s && we_r && in_range_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  // Transaction FSM with registered ack/busy/err/rdata.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'd0;
          if (bus.req_i) begin
            we_r    <= bus.we_i;
            addr_r  <= bus.addr_i;
            wdata_r <= bus.wdata_i;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
            state_r <= WAIT;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ACK;
            ack_r   <= 1'b1;
            err_r   <= ~in_range_s;
            // Writes and faulting requests both return zero data.
            if (in_range_s && !we_r) begin
              rdata_r <= mem_r[idx_s];
            end else begin
              rdata_r <= 32'd0;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ACK: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'd0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          ack_r   <= 1'b0;
          busy_r  <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= 32'd0;
        end
      endcase
    end
  end

  assign bus.ack_o   = ack_r;
  assign bus.busy_o  = busy_r;
  assign bus.err_o   = err_r;
  assign bus.rdata_o = rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder at LATENCY=3 (256 words) and LATENCY=1 (16 words),
// checked every cycle against a transaction-level model of timing and storage.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus3();
  dmem_responder_if bus1();

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus3.slave)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Model state, index 0 = LATENCY 3 instance, index 1 = LATENCY 1 instance.
  logic [31:0] ref_mem  [2][256];
  int          nxt_free [2];
  int          acc_edge [2];
  int          ack_edge [2];
  logic        p_we     [2];
  logic [31:0] p_addr   [2];
  logic [31:0] p_wd     [2];
  logic [31:0] exp_rd   [2];
  logic        exp_err  [2];
  logic [31:0] last_rd  [2];
  logic        last_err [2];
  int          n_acks   [2];

  function automatic int lat_of(input int s);
    return (s == 1) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int s);
    return (s == 1) ? 16 : 256;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      acc_edge[s] = -100;
      ack_edge[s] = -100;
      nxt_free[s] = edge_cnt + 1;
    end
  endtask

  task automatic check_quiet(input string tag);
    chk_eq({tag, "_ack3"},  {31'd0, bus3.ack_o},  32'd0);
    chk_eq({tag, "_busy3"}, {31'd0, bus3.busy_o}, 32'd0);
    chk_eq({tag, "_err3"},  {31'd0, bus3.err_o},  32'd0);
    chk_eq({tag, "_rd3"},   bus3.rdata_o,         32'd0);
    chk_eq({tag, "_ack1"},  {31'd0, bus1.ack_o},  32'd0);
    chk_eq({tag, "_busy1"}, {31'd0, bus1.busy_o}, 32'd0);
  endtask

  // One clock of stimulus on instance s, followed by a full output check against the model.
  task automatic step(input int s, input logic req, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int          e;
    int          widx;
    logic        ok;
    logic        o_ack, o_busy, o_err;
    logic [31:0] o_rd;
    logic        hit;
    @(negedge clk);
    if (s == 1) begin
      bus1.req_i = req; bus1.we_i = we; bus1.addr_i = addr; bus1.wdata_i = wdata;
      bus3.req_i = 1'b0;
    end else begin
      bus3.req_i = req; bus3.we_i = we; bus3.addr_i = addr; bus3.wdata_i = wdata;
      bus1.req_i = 1'b0;
    end
    @(posedge clk);
    #1;
    e = edge_cnt;
    if (req && (e >= nxt_free[s])) begin
      acc_edge[s] = e;
      ack_edge[s] = e + lat_of(s);
      nxt_free[s] = e + lat_of(s) + 2;
      p_we[s]     = we;
      p_addr[s]   = addr;
      p_wd[s]     = wdata;
    end
    hit = (e == ack_edge[s]);
    if (hit) begin
      ok = (p_addr[s][1:0] == 2'b00) && (p_addr[s][31:2] < depth_of(s));
      exp_err[s] = ~ok;
      exp_rd[s]  = 32'd0;
      if (ok) begin
        widx = int'(p_addr[s][31:2]);
        if (p_we[s]) ref_mem[s][widx] = p_wd[s];
        else         exp_rd[s] = ref_mem[s][widx];
      end
    end
    if (s == 1) begin
      o_ack = bus1.ack_o; o_busy = bus1.busy_o; o_err = bus1.err_o; o_rd = bus1.rdata_o;
    end else begin
      o_ack = bus3.ack_o; o_busy = bus3.busy_o; o_err = bus3.err_o; o_rd = bus3.rdata_o;
    end
    chk_eq($sformatf("ack%0d", s),  {31'd0, o_ack},  {31'd0, hit});
    chk_eq($sformatf("busy%0d", s), {31'd0, o_busy},
           {31'd0, (e >= acc_edge[s]) && (e <= ack_edge[s])});
    chk_eq($sformatf("err%0d", s),  {31'd0, o_err},  hit ? {31'd0, exp_err[s]} : 32'd0);
    chk_eq($sformatf("rdata%0d", s), o_rd,           hit ? exp_rd[s] : 32'd0);
    if (o_ack) begin
      last_rd[s]  = o_rd;
      last_err[s] = o_err;
      n_acks[s]++;
    end
  endtask

  // A full transaction with random junk on the request lines while the DUT is busy.
  task automatic txn(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int a0;
    a0 = n_acks[s];
    last_rd[s]  = 32'hA5A5_A5A5;
    last_err[s] = 1'b1;
    step(s, 1'b1, we, addr, wdata);
    repeat (lat_of(s) + 1)
      step(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    chk_eq($sformatf("txn_acks%0d", s), 32'(n_acks[s] - a0), 32'd1);
  endtask

  function automatic logic [31:0] gen_addr(input int s);
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6)      return {22'd0, 8'($urandom_range(0, depth_of(s) - 1)), 2'b00};
    else if (r == 7) return {22'd0, 8'($urandom_range(0, depth_of(s) - 1)), 2'($urandom_range(1, 3))};
    else if (r == 8) return 32'($urandom_range(depth_of(s), depth_of(s) + 4000)) << 2;
    else             return $urandom;
  endfunction

  logic [31:0] val;
  logic [31:0] prior;
  int          a_start;

  initial begin
    bus3.req_i = 1'b0; bus3.we_i = 1'b0; bus3.addr_i = 32'd0; bus3.wdata_i = 32'd0;
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = 32'd0; bus1.wdata_i = 32'd0;
    n_acks[0] = 0;
    n_acks[1] = 0;

    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    #1;
    rst = 1'b0;
    model_reset();

    // First request right after reset: write 0x10.
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    for (int i = 0; i < 256; i++)
      if (i != 4) txn(0, 1'b1, 32'(i) << 2, $urandom);

    txn(0, 1'b0, 32'h0000_0010, 32'd0);
    chk_eq("rd_10", last_rd[0], 32'hDEAD_BEEF);
    chk_eq("rd_10_err", {31'd0, last_err[0]}, 32'd0);
    txn(0, 1'b0, 32'h0000_0013, 32'd0);
    chk_eq("misal_err", {31'd0, last_err[0]}, 32'd1);
    chk_eq("misal_rd", last_rd[0], 32'd0);
    txn(0, 1'b0, 32'h0000_0400, 32'd0);
    chk_eq("oor_err", {31'd0, last_err[0]}, 32'd1);
    chk_eq("oor_rd", last_rd[0], 32'd0);
    txn(0, 1'b1, 32'h0000_0011, 32'h0BAD_0BAD);
    txn(0, 1'b0, 32'h0000_0010, 32'd0);
    chk_eq("rd_10_again", last_rd[0], 32'hDEAD_BEEF);

    // Request held high with a new address every cycle.
    a_start = n_acks[0];
    for (int i = 0; i < 40; i++)
      step(0, 1'b1, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
    chk_eq("stream_acks", 32'(n_acks[0] - a_start), 32'((40 + lat_of(0) + 1) / (lat_of(0) + 2)));
    repeat (lat_of(0) + 2) step(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Random traffic on the LATENCY 3 instance.
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), gen_addr(0), $urandom);
    repeat (lat_of(0) + 2) step(0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset in the middle of a write.
    prior = ref_mem[0][8];
    step(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    step(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("midwait_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    txn(0, 1'b0, 32'h0000_0020, 32'd0);
    chk_eq("rd_20_after_rst", last_rd[0], prior);

    // LATENCY 1 instance: fill storage, write/read word 0, then random traffic.
    for (int i = 0; i < 16; i++)
      txn(1, 1'b1, 32'(i) << 2, $urandom);
    val = $urandom;
    txn(1, 1'b1, 32'h0000_0000, val);
    txn(1, 1'b0, 32'h0000_0000, 32'd0);
    chk_eq("l1_rd_0", last_rd[1], val);
    for (int i = 0; i < 200; i++)
      step(1, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), gen_addr(1), $urandom);
    repeat (lat_of(1) + 2) step(1, 1'b0, 1'b0, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
